serdesphy_ana_tx_driver_ctrl: RTL and testbench

Power, isolation and mode sequencer for the TX CML differential driver. Walks the driver through a fixed bring-up order: isolated, enabled while isolated, idle pattern, then live data. Handles loopback entry/exit, PLL lock loss and orderly shutdown, so the driver never sees an illegal enable/iso/lpbk combination. Sits between the PHY control registers and the analog TX driver and data-gating mux.

---
 rtl/serdesphy_pkg.sv | 35 +++
 rtl/serdesphy_dwell_counter.sv | 46 ++++
 rtl/serdesphy_ana_tx_driver_ctrl.sv | 176 +++++++++++++++++
 tb/tb_serdesphy_ana_tx_driver_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// ============================================================================
// Module      : serdesphy_pkg
// Description : Shared TX driver control definitions: 3-bit state encoding
//               (also used by CSR status readback) and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serdesphy_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        c_ST_OFF       = 3'd0,
        c_ST_WAIT_LOCK = 3'd1,
        c_ST_SETTLE    = 3'd2,
        c_ST_IDLE_PAT  = 3'd3,
        c_ST_ACTIVE    = 3'd4,
        c_ST_LPBK      = 3'd5,
        c_ST_SHUTDN    = 3'd6,
        c_ST_FAULT     = 3'd7
    } txctl_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A counter must hold PARAM-1 for the largest dwell; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serdesphy_dwell_counter.sv
// ============================================================================
// Module      : serdesphy_dwell_counter
// Description : Saturating dwell counter with synchronous clear and a
//               terminal-value compare flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdesphy_dwell_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_terminal,
    output logic             o_at_end
);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;
    logic             w_sat;

    always_comb begin
        w_sat     = &r_count_q;
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && !w_sat) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_at_end = (r_count_q == i_terminal);

endmodule

`default_nettype wire

// File: rtl/serdesphy_ana_tx_driver_ctrl.sv
// ============================================================================
// Module      : serdesphy_ana_tx_driver_ctrl
// Description : Power / isolation / mode sequencer for the TX CML driver.
//               Optional lock-timeout fault: SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdesphy_ana_tx_driver_ctrl
    import serdesphy_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int IDLE_CYCLES   = 16,
    parameter int GUARD_CYCLES  = 8,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_req,
    input  logic       lpbk_req,
    input  logic       pll_lock,
    output logic       drv_enable,
    output logic       drv_iso_en,
    output logic       drv_lpbk_en,
    output logic       data_gate,
    output logic       tx_ready,
    output logic [2:0] state,
    output logic       lock_fault
);

`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
    localparam int c_CNT_MAX = max_int(max_int(SETTLE_CYCLES, IDLE_CYCLES),
                                       max_int(GUARD_CYCLES, LOCK_TIMEOUT));
`else
    localparam int c_CNT_MAX = max_int(max_int(SETTLE_CYCLES, IDLE_CYCLES),
                                       GUARD_CYCLES);
`endif
    localparam int c_CNT_W = cnt_width(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_SETTLE_TERM = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_TERM   = c_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_TERM  = c_CNT_W'(GUARD_CYCLES - 1);
`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_LOCK_TERM   = c_CNT_W'(LOCK_TIMEOUT - 1);
`endif

    txctl_state_e         r_state_q;
    txctl_state_e         w_state_d;
    logic                 w_state_chg;
    logic                 w_at_end;
    logic [c_CNT_W-1:0]   w_terminal;

    // Terminal value for the dwell of the current state.
    always_comb begin
        w_terminal = '0;
        case (r_state_q)
            c_ST_SETTLE:    w_terminal = c_SETTLE_TERM;
            c_ST_IDLE_PAT:  w_terminal = c_IDLE_TERM;
            c_ST_SHUTDN:    w_terminal = c_GUARD_TERM;
`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
            c_ST_WAIT_LOCK: w_terminal = c_LOCK_TERM;
`endif
            default:        w_terminal = '0;
        endcase
    end

    assign w_state_chg = (w_state_d != r_state_q);

    serdesphy_dwell_counter #(
        .CNT_W      (c_CNT_W)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_state_chg),
        .i_enable   (1'b1),
        .i_terminal (w_terminal),
        .o_at_end   (w_at_end)
    );

    // Request drop beats lock loss, which beats normal progression.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_OFF: begin
                if (tx_en_req) w_state_d = c_ST_WAIT_LOCK;
            end
            c_ST_WAIT_LOCK: begin
                if (!tx_en_req)    w_state_d = c_ST_OFF;
                else if (pll_lock) w_state_d = c_ST_SETTLE;
`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
                else if (w_at_end) w_state_d = c_ST_FAULT;
`endif
            end
            c_ST_SETTLE: begin
                if (!tx_en_req)     w_state_d = c_ST_SHUTDN;
                else if (!pll_lock) w_state_d = c_ST_WAIT_LOCK;
                else if (w_at_end)  w_state_d = c_ST_IDLE_PAT;
            end
            c_ST_IDLE_PAT: begin
                if (!tx_en_req)     w_state_d = c_ST_SHUTDN;
                else if (!pll_lock) w_state_d = c_ST_WAIT_LOCK;
                else if (w_at_end)  w_state_d = lpbk_req ? c_ST_LPBK : c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (!tx_en_req)     w_state_d = c_ST_SHUTDN;
                else if (!pll_lock) w_state_d = c_ST_WAIT_LOCK;
                else if (lpbk_req)  w_state_d = c_ST_LPBK;
            end
            c_ST_LPBK: begin
                if (!tx_en_req)     w_state_d = c_ST_SHUTDN;
                else if (!pll_lock) w_state_d = c_ST_WAIT_LOCK;
                else if (!lpbk_req) w_state_d = c_ST_IDLE_PAT;
            end
            c_ST_SHUTDN: begin
                if (w_at_end) w_state_d = c_ST_OFF;
            end
            c_ST_FAULT: begin
                if (!tx_en_req) w_state_d = c_ST_OFF;
            end
            default: w_state_d = c_ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_OFF;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        drv_enable  = 1'b0;
        drv_iso_en  = 1'b1;
        drv_lpbk_en = 1'b0;
        data_gate   = 1'b1;
        tx_ready    = 1'b0;
        case (r_state_q)
            c_ST_SETTLE: begin
                drv_enable = 1'b1;
            end
            c_ST_IDLE_PAT: begin
                drv_enable = 1'b1;
                drv_iso_en = 1'b0;
            end
            c_ST_ACTIVE: begin
                drv_enable = 1'b1;
                drv_iso_en = 1'b0;
                data_gate  = 1'b0;
                tx_ready   = 1'b1;
            end
            c_ST_LPBK: begin
                drv_enable  = 1'b1;
                drv_iso_en  = 1'b0;
                drv_lpbk_en = 1'b1;
            end
            c_ST_SHUTDN: begin
                drv_enable = 1'b1;
            end
            default: begin
                drv_enable = 1'b0;
            end
        endcase
    end

    assign state = r_state_q;

`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
    assign lock_fault = (r_state_q == c_ST_FAULT);
`else
    assign lock_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serdesphy_ana_tx_driver_ctrl.sv
// ============================================================================
// Module      : tb_serdesphy_ana_tx_driver_ctrl
// Description : Self-checking bench: directed scenarios plus random inputs
//               against a behavioural model of the TX driver sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serdesphy_ana_tx_driver_ctrl;

    localparam int SETTLE = 4;
    localparam int IDLE   = 2;
    localparam int GUARD  = 3;
    localparam int LOCKTO = 10;

    // en/iso/lpbk/gate/ready per state code
    localparam logic [4:0] EXP_TBL [0:7] = '{
        5'b01010, 5'b01010, 5'b11010, 5'b10010,
        5'b10001, 5'b10110, 5'b11010, 5'b01010
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en_req = 1'b0;
    logic       lpbk_req = 1'b0;
    logic       pll_lock = 1'b0;
    logic       drv_enable, drv_iso_en, drv_lpbk_en, data_gate, tx_ready, lock_fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    int  m_st = 0;
    int  m_dw = 0;
    bit  m_valid = 1'b0;
    logic prev_en = 1'b0;

    serdesphy_ana_tx_driver_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .IDLE_CYCLES   (IDLE),
        .GUARD_CYCLES  (GUARD),
        .LOCK_TIMEOUT  (LOCKTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en_req   (tx_en_req),
        .lpbk_req    (lpbk_req),
        .pll_lock    (pll_lock),
        .drv_enable  (drv_enable),
        .drv_iso_en  (drv_iso_en),
        .drv_lpbk_en (drv_lpbk_en),
        .data_gate   (data_gate),
        .tx_ready    (tx_ready),
        .state       (state),
        .lock_fault  (lock_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_next(int st, int dw, bit en, bit lp, bit lk);
        case (st)
            0: return en ? 1 : 0;
            1: begin
                if (!en) return 0;
                if (lk) return 2;
`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
                if (dw == LOCKTO - 1) return 7;
`endif
                return 1;
            end
            2, 3, 4, 5: begin
                if (!en) return 6;
                if (!lk) return 1;
                if (st == 2) return (dw == SETTLE - 1) ? 3 : 2;
                if (st == 3) return (dw == IDLE - 1) ? (lp ? 5 : 4) : 3;
                if (st == 4) return lp ? 5 : 4;
                return lp ? 5 : 3;
            end
            6: return (dw == GUARD - 1) ? 0 : 6;
            default: return en ? 7 : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int ns;
        if (rst) begin
            m_st    = 0;
            m_dw    = 0;
            m_valid = 1'b1;
        end else begin
            ns   = model_next(m_st, m_dw, tx_en_req, lpbk_req, pll_lock);
            m_dw = (ns == m_st) ? m_dw + 1 : 0;
            m_st = ns;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_state", int'(state), m_st);
            chk("model_outs", int'({drv_enable, drv_iso_en, drv_lpbk_en, data_gate, tx_ready}),
                int'(EXP_TBL[m_st]));
            chk("model_lock_fault", int'(lock_fault), (m_st == 7) ? 1 : 0);
            chk("inv_lpbk", int'(drv_lpbk_en && !(drv_enable && !drv_iso_en && data_gate)), 0);
            chk("inv_en_rise", int'(drv_enable && !prev_en && !drv_iso_en), 0);
            prev_en = drv_enable;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_en"}, int'(drv_enable), 0);
        chk({tag, "_iso"}, int'(drv_iso_en), 1);
        chk({tag, "_lpbk"}, int'(drv_lpbk_en), 0);
        chk({tag, "_gate"}, int'(data_gate), 1);
        chk({tag, "_ready"}, int'(tx_ready), 0);
        chk({tag, "_fault"}, int'(lock_fault), 0);
    endtask

    initial begin
        int path [8];
        path = '{1, 2, 2, 2, 2, 3, 3, 4};

        tick();
        tick();
        chk_reset_vals("reset");

        // Bring-up
        rst = 1'b0; tx_en_req = 1'b1; pll_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bringup_state", int'(state), path[i]);
            chk("bringup_iso", int'(drv_iso_en), (path[i] >= 3) ? 0 : 1);
        end
        chk("bringup_ready", int'(tx_ready), 1);

        // Loopback entry/exit
        lpbk_req = 1'b1; tick();
        chk("lpbk_state", int'(state), 5);
        chk("lpbk_outs", int'({drv_lpbk_en, data_gate, tx_ready}), 3'b110);
        lpbk_req = 1'b0; tick();
        chk("lpbk_exit_idle0", int'(state), 3);
        tick();
        chk("lpbk_exit_idle1", int'(state), 3);
        tick();
        chk("lpbk_exit_active", int'(state), 4);

        // Shutdown with ignored re-request
        tx_en_req = 1'b0; tick();
        chk("shut_state0", int'(state), 6);
        chk("shut_en_iso", int'({drv_enable, drv_iso_en}), 2'b11);
        tx_en_req = 1'b1; tick();
        chk("shut_state1", int'(state), 6);
        tx_en_req = 1'b0; tick();
        chk("shut_state2", int'(state), 6);
        tick();
        chk("shut_off", int'(state), 0);
        chk("shut_off_en", int'(drv_enable), 0);

        // Lock loss in LPBK, restore, simultaneous drop
        tx_en_req = 1'b1; tick();
        chk("relock_wait", int'(state), 1);
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("reup_active", int'(state), 4);
        lpbk_req = 1'b1; tick();
        chk("reup_lpbk", int'(state), 5);
        pll_lock = 1'b0; tick();
        chk("lockloss_state", int'(state), 1);
        chk("lockloss_outs", int'({drv_enable, drv_iso_en, drv_lpbk_en}), 3'b010);
        pll_lock = 1'b1; tick();
        chk("restore_settle", int'(state), 2);
        for (int i = 0; i < 4; i++) tick();
        chk("restore_idle", int'(state), 3);
        tick(); tick();
        chk("restore_lpbk", int'(state), 5);
        pll_lock = 1'b0; tx_en_req = 1'b0; tick();
        chk("simul_drop_shutdn", int'(state), 6);
        pll_lock = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("simul_drop_off", int'(state), 0);
        lpbk_req = 1'b0;

        // Reset mid-SETTLE
        tx_en_req = 1'b1; tick(); tick(); tick();
        chk("pre_rst_settle", int'(state), 2);
        rst = 1'b1; tick();
        chk_reset_vals("midrst");
        rst = 1'b0;

        // Lock timeout
        pll_lock = 1'b0; tick();
        chk("to_wait", int'(state), 1);
        for (int i = 0; i < 9; i++) tick();
        chk("to_still_wait", int'(state), 1);
        tick();
`ifdef SERDESPHY_TXCTL_LOCK_TIMEOUT_EN
        chk("to_fault", int'(state), 7);
        chk("to_fault_flag", int'(lock_fault), 1);
`else
        chk("to_no_fault", int'(state), 1);
        chk("to_no_fault_flag", int'(lock_fault), 0);
`endif
        tx_en_req = 1'b0; tick();
        chk("to_off", int'(state), 0);
        chk("to_off_flag", int'(lock_fault), 0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            tx_en_req = ($urandom_range(0, 19) != 0);
            pll_lock  = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 15) == 0) lpbk_req = ~lpbk_req;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
